// File: rtl/skel_thin_engine.sv
// Zhang-Suen thinning engine: loads a binary raster and iterates both subiterations
// until an iteration deletes nothing or MAX_ITER is reached, then streams the skeleton out.
module skel_thin_engine #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 6,
    parameter int MAX_ITER = 16,
    parameter int IT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             done,
    output logic [IT_W-1:0]  iter_count,
    output logic             converged
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int MEM  = 2 ** ADDR_W;
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SCAN1, COMMIT1, SCAN2, COMMIT2, CHECK, UNLOAD
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [MEM-1:0]     bitmap_q, bitmap_d;
    logic [MEM-1:0]     mask_q, mask_d;
    logic               loaded_q, loaded_d;
    logic               changed_q, changed_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic               conv_q, conv_d;
    logic               done_q, done_d;

    logic [7:0] nb;
    logic [7:0] nb_rot;
    logic [3:0] b_cnt, a_cnt;
    logic       c1, c2, core, del_bit;

    // Neighbours outside the image read as background.
    function automatic logic pix(input logic [MEM-1:0] bm, input int x, input int y);
        if (x < 0 || x >= IMG_W || y < 0 || y >= IMG_H) return 1'b0;
        return bm[ADDR_W'(y * IMG_W + x)];
    endfunction

    always_comb begin
        nb[0]  = pix(bitmap_q, int'(x_q),     int'(y_q) - 1);
        nb[1]  = pix(bitmap_q, int'(x_q) + 1, int'(y_q) - 1);
        nb[2]  = pix(bitmap_q, int'(x_q) + 1, int'(y_q));
        nb[3]  = pix(bitmap_q, int'(x_q) + 1, int'(y_q) + 1);
        nb[4]  = pix(bitmap_q, int'(x_q),     int'(y_q) + 1);
        nb[5]  = pix(bitmap_q, int'(x_q) - 1, int'(y_q) + 1);
        nb[6]  = pix(bitmap_q, int'(x_q) - 1, int'(y_q));
        nb[7]  = pix(bitmap_q, int'(x_q) - 1, int'(y_q) - 1);
        // bit i of nb_rot is the cyclic successor of bit i, so ~nb & nb_rot marks 0->1 steps
        nb_rot  = {nb[0], nb[7:1]};
        b_cnt   = 4'($countones(nb));
        a_cnt   = 4'($countones(~nb & nb_rot));
        c1      = !(nb[0] & nb[2] & nb[4]) && !(nb[2] & nb[4] & nb[6]);
        c2      = !(nb[0] & nb[2] & nb[6]) && !(nb[0] & nb[4] & nb[6]);
        core    = bitmap_q[addr_q] && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) && (a_cnt == 4'd1);
        del_bit = core && ((state_q == SCAN1) ? c1 : c2);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x_d       = x_q;
        y_d       = y_q;
        bitmap_d  = bitmap_q;
        mask_d    = mask_q;
        loaded_d  = loaded_q;
        changed_d = changed_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (in_valid && !loaded_q) begin
                    bitmap_d[addr_q] = |in_data;
                    if (addr_q == A_LAST) begin
                        addr_d   = '0;
                        loaded_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = LOAD;
                    end
                end else if (state_q == IDLE && start && loaded_q) begin
                    state_d   = SCAN1;
                    iter_d    = '0;
                    conv_d    = 1'b0;
                    changed_d = 1'b0;
                    addr_d    = '0;
                    x_d       = '0;
                    y_d       = '0;
                end
            end
            SCAN1, SCAN2: begin
                mask_d[addr_q] = del_bit;
                if (addr_q == A_LAST) begin
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = (state_q == SCAN1) ? COMMIT1 : COMMIT2;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            COMMIT1, COMMIT2: begin
                bitmap_d  = bitmap_q & ~mask_q;
                mask_d    = '0;
                changed_d = changed_q | (|mask_q);
                state_d   = (state_q == COMMIT1) ? SCAN2 : CHECK;
            end
            CHECK: begin
                iter_d = iter_q + IT_W'(1);
                if (!changed_q) begin
                    conv_d  = 1'b1;
                    state_d = UNLOAD;
                end else if (iter_q + IT_W'(1) == IT_W'(MAX_ITER)) begin
                    state_d = UNLOAD;
                end else begin
                    changed_d = 1'b0;
                    state_d   = SCAN1;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (addr_q == A_LAST) begin
                        addr_d   = '0;
                        loaded_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bitmap_q  <= '0;
            mask_q    <= '0;
            loaded_q  <= 1'b0;
            changed_q <= 1'b0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bitmap_q  <= bitmap_d;
            mask_q    <= mask_d;
            loaded_q  <= loaded_d;
            changed_q <= changed_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            done_q    <= done_d;
        end
    end

    assign in_ready   = (state_q == IDLE || state_q == LOAD) && !loaded_q;
    assign busy       = !(state_q == IDLE || state_q == LOAD);
    assign out_valid  = (state_q == UNLOAD);
    assign out_data   = out_valid ? {PIX_W{bitmap_q[addr_q]}} : '0;
    assign done       = done_q;
    assign iter_count = iter_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_skel_thin_engine.sv
// Bench for skel_thin_engine: table of images run against a behavioural Zhang-Suen model,
// with output beats checked from a scoreboard queue, plus reset and start-ignore sequences.
module tb_skel_thin_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_a  [2];
    logic [7:0] in_data_a   [2];
    logic       start_a     [2];
    logic       out_ready_a [2];
    logic       in_ready_a  [2];
    logic       busy_a      [2];
    logic       out_valid_a [2];
    logic [7:0] out_data_a  [2];
    logic       done_a      [2];
    logic [4:0] iter_a      [2];
    logic       conv_a      [2];

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    skel_thin_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data_a[0]),
        .start(start_a[0]), .busy(busy_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_data(out_data_a[0]),
        .done(done_a[0]), .iter_count(iter_a[0]), .converged(conv_a[0])
    );

    skel_thin_engine #(.MAX_ITER(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data_a[1]),
        .start(start_a[1]), .busy(busy_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_data(out_data_a[1]),
        .done(done_a[1]), .iter_count(iter_a[1]), .converged(conv_a[1])
    );

    typedef struct {
        logic [63:0] img;
        int          sel;
        int          exp_it;
        bit          exp_cv;
        bit          use_model;
        bit          bp;
        string       nm;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit mpix(input logic [63:0] bm, input int x, input int y);
        logic [5:0] idx;
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
        idx = 6'(y * 8 + x);
        return bm[idx];
    endfunction

    task automatic model(input logic [63:0] img, input int maxit,
                         output logic [63:0] res, output int it, output bit cv);
        logic [63:0] bm, del;
        logic [5:0]  idx;
        bit chg, cond, p2, p3, p4, p5, p6, p7, p8, p9;
        int b, a;
        bm = img; it = 0; cv = 1'b0;
        for (int k = 0; k < maxit; k++) begin
            chg = 1'b0;
            for (int sub = 0; sub < 2; sub++) begin
                del = '0;
                for (int y = 0; y < 8; y++) begin
                    for (int x = 0; x < 8; x++) begin
                        if (mpix(bm, x, y)) begin
                            p2 = mpix(bm, x, y - 1);     p3 = mpix(bm, x + 1, y - 1);
                            p4 = mpix(bm, x + 1, y);     p5 = mpix(bm, x + 1, y + 1);
                            p6 = mpix(bm, x, y + 1);     p7 = mpix(bm, x - 1, y + 1);
                            p8 = mpix(bm, x - 1, y);     p9 = mpix(bm, x - 1, y - 1);
                            b = int'(p2) + int'(p3) + int'(p4) + int'(p5)
                              + int'(p6) + int'(p7) + int'(p8) + int'(p9);
                            a = int'(!p2 && p3) + int'(!p3 && p4) + int'(!p4 && p5)
                              + int'(!p5 && p6) + int'(!p6 && p7) + int'(!p7 && p8)
                              + int'(!p8 && p9) + int'(!p9 && p2);
                            if (sub == 0) cond = !(p2 && p4 && p6) && !(p4 && p6 && p8);
                            else          cond = !(p2 && p4 && p8) && !(p2 && p6 && p8);
                            if (b >= 2 && b <= 6 && a == 1 && cond) begin
                                idx = 6'(y * 8 + x);
                                del[idx] = 1'b1;
                            end
                        end
                    end
                end
                bm = bm & ~del;
                if (del != '0) chg = 1'b1;
            end
            it++;
            if (!chg) begin
                cv = 1'b1;
                break;
            end
        end
        res = bm;
    endtask

    task automatic chk_reset(input int s, input string tag);
        chk({tag, " in_ready"},   32'(in_ready_a[s]),  32'd1);
        chk({tag, " busy"},       32'(busy_a[s]),      32'd0);
        chk({tag, " done"},       32'(done_a[s]),      32'd0);
        chk({tag, " out_valid"},  32'(out_valid_a[s]), 32'd0);
        chk({tag, " out_data"},   32'(out_data_a[s]),  32'd0);
        chk({tag, " iter_count"}, 32'(iter_a[s]),      32'd0);
        chk({tag, " converged"},  32'(conv_a[s]),      32'd0);
    endtask

    task automatic load(input int s, input logic [63:0] img);
        int notready;
        logic [5:0] idx;
        notready = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            idx = 6'(i);
            in_valid_a[s] = 1'b1;
            in_data_a[s]  = img[idx] ? 8'($urandom_range(1, 255)) : 8'h00;
            if (!in_ready_a[s]) notready++;
        end
        // extra beats offered while full must be dropped
        repeat (2) begin
            @(negedge clk);
            in_data_a[s] = 8'hFF;
        end
        @(negedge clk);
        in_valid_a[s] = 1'b0;
        in_data_a[s]  = 8'h00;
        chk("in_ready during load", 32'(notready), 32'd0);
        chk("in_ready after full", 32'(in_ready_a[s]), 32'd0);
    endtask

    task automatic run_case(input vec_t v);
        logic [63:0] res;
        logic [5:0]  idx;
        logic [7:0]  e, prev;
        int mit, eit, cyc, first_v, beat;
        bit mcv, ecv, got_done, stall;
        int s;
        s = v.sel;
        model(v.img, (s == 1) ? 1 : 16, res, mit, mcv);
        eit = v.use_model ? mit : v.exp_it;
        ecv = v.use_model ? mcv : v.exp_cv;
        load(s, v.img);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            idx = 6'(i);
            exp_q.push_back(res[idx] ? 8'hFF : 8'h00);
        end
        @(negedge clk);
        start_a[s] = 1'b1;
        cyc = 0; first_v = -1; got_done = 1'b0; stall = 1'b0; beat = 0; prev = '0;
        while (!got_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start_a[s] = 1'b0;
            if (cyc == 1) chk({v.nm, " busy after start"}, 32'(busy_a[s]), 32'd1);
            if (stall) begin
                chk({v.nm, " stall valid held"}, 32'(out_valid_a[s]), 32'd1);
                chk({v.nm, " stall data stable"}, 32'(out_data_a[s]), 32'(prev));
            end
            if (done_a[s]) begin
                got_done = 1'b1;
                chk({v.nm, " busy low at done"}, 32'(busy_a[s]), 32'd0);
            end else begin
                if (out_valid_a[s] && first_v < 0) first_v = cyc;
                out_ready_a[s] = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_valid_a[s] && out_ready_a[s]) begin
                    if (exp_q.size() == 0) begin
                        chk({v.nm, " extra beat"}, 32'(beat), 32'd64);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("%s beat %0d", v.nm, beat), 32'(out_data_a[s]), 32'(e));
                    end
                    beat++;
                end
                stall = out_valid_a[s] && !out_ready_a[s];
                prev  = out_data_a[s];
            end
        end
        out_ready_a[s] = 1'b0;
        chk({v.nm, " done seen"}, 32'(got_done), 32'd1);
        chk({v.nm, " beats left"}, 32'(exp_q.size()), 32'd0);
        chk({v.nm, " iter_count"}, 32'(iter_a[s]), 32'(eit));
        chk({v.nm, " converged"}, 32'(conv_a[s]), 32'(ecv));
        chk({v.nm, " first out_valid cycle"}, 32'(first_v), 32'(eit * 131 + 1));
        if (!v.bp) chk({v.nm, " done cycle"}, 32'(cyc), 32'(eit * 131 + 65));
        @(negedge clk);
        chk({v.nm, " done one cycle"}, 32'(done_a[s]), 32'd0);
        chk({v.nm, " iter_count held"}, 32'(iter_a[s]), 32'(eit));
        chk({v.nm, " converged held"}, 32'(conv_a[s]), 32'(ecv));
        chk({v.nm, " in_ready after run"}, 32'(in_ready_a[s]), 32'd1);
    endtask

    task automatic start_ignored(input int s, input string tag);
        @(negedge clk);
        start_a[s] = 1'b1;
        @(negedge clk);
        start_a[s] = 1'b0;
        chk({tag, " start ignored busy"}, 32'(busy_a[s]), 32'd0);
        @(negedge clk);
        chk({tag, " start ignored busy+1"}, 32'(busy_a[s]), 32'd0);
    endtask

    initial begin
        int bad;
        vec_t rv;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid_a[s] = 1'b0; in_data_a[s] = '0; start_a[s] = 1'b0; out_ready_a[s] = 1'b0;
        end

        tbl[0] = '{64'h0,                     0, 1, 1'b1, 1'b0, 1'b0, "zero"};
        tbl[1] = '{64'h1 << 27,               0, 1, 1'b1, 1'b0, 1'b0, "single"};
        tbl[2] = '{64'h0000_003E_0000_0000,   0, 1, 1'b1, 1'b0, 1'b1, "hline"};
        tbl[3] = '{64'h0000_0000_0006_0600,   0, 2, 1'b1, 1'b0, 1'b0, "block2x2"};
        tbl[4] = '{64'h0000_0000_0006_0600,   1, 1, 1'b0, 1'b0, 1'b0, "block2x2_cap1"};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF,   0, 0, 1'b0, 1'b1, 1'b1, "full"};
        tbl[6] = '{{$urandom, $urandom},      0, 0, 1'b0, 1'b1, 1'b1, "random"};
        tbl[7] = '{{$urandom, $urandom} | {$urandom, $urandom}, 0, 0, 1'b0, 1'b1, 1'b0, "dense"};

        repeat (2) @(negedge clk);
        chk_reset(0, "reset");
        chk_reset(1, "reset dut1");
        rst_n = 1'b1;
        start_ignored(0, "unloaded");

        for (int i = 0; i < 8; i++) run_case(tbl[i]);

        // abort a second run in the middle of SCAN2
        load(0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (95) @(negedge clk);
        chk("busy before abort", 32'(busy_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset(0, "async abort");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        out_ready_a[0] = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (out_valid_a[0] || done_a[0] || busy_a[0]) bad++;
        end
        out_ready_a[0] = 1'b0;
        chk("no output after abort", 32'(bad), 32'd0);
        chk_reset(0, "after abort");
        start_ignored(0, "after abort");
        rv = tbl[1];
        rv.nm = "single after abort";
        run_case(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skel_thin_engine.md
# skel_thin_engine

Self-contained, parametrised Zhang-Suen thinning engine: streams in a binary image, iterates the two-subiteration thinning rule until no pixel changes or an iteration cap is reached, then streams the skeleton out. It is the next-generation successor to the current skeletonization top level. The image store, raster counter, write arbitration and centre-mask evaluation are folded into one block. The block adds a valid/ready load and unload handshake, a convergence loop, and free image dimensions.

## Interface
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in pixels (≥3)
- PIX_W, 8, input/output pixel width
- ADDR_W, 6, raster address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- MAX_ITER, 16, maximum full iterations (≥1)
- IT_W, 5, width of iteration counter; must hold MAX_ITER

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  engine accepts input pixel
- in_data  in  PIX_W  pixel; nonzero = foreground
- start  in  1  begin thinning (single-cycle pulse)
- busy  out  1  high from start accept until last output beat accepted
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output pixel
- out_data  out  PIX_W  all ones = foreground, zero = background
- done  out  1  one-cycle pulse after last output beat
- iter_count  out  IT_W  full iterations executed in current/last run
- converged  out  1  last run ended because an iteration deleted nothing

## Operation
- Storage: IMG_W*IMG_H single-bit flops (bitmap) plus same-size delete-mask flops; out-of-image neighbours read as 0.
- States: IDLE, LOAD, SCAN1, COMMIT1, SCAN2, COMMIT2, CHECK, UNLOAD.
- IDLE/LOAD:
  - in_ready=1 until the image is full.
  - Each handshake writes bitmap[addr] = |in_data; addr increments in raster order.
  - After the IMG_W*IMG_H-th beat, loaded=1 and in_ready=0.
- start is honoured only in IDLE with loaded=1; otherwise it is ignored. On accept: iter_count=0, converged=0, go to SCAN1.
- SCAN1/SCAN2 evaluate one pixel per cycle in raster order. Let P1 = centre and P2..P9 = N, NE, E, SE, S, SW, W, NW. Let B = count of set P2..P9 and A = count of 0→1 transitions in the cyclic sequence P2..P9,P2. Then mask[addr] = P1 & (2≤B≤6) & (A==1) & C, where:
  - SCAN1: C = !(P2&P4&P6) & !(P4&P6&P8)
  - SCAN2: C = !(P2&P4&P8) & !(P2&P6&P8)
- Scans read only the bitmap. It is not modified during a scan.
- COMMIT: bitmap &= ~mask and mask is cleared, in one cycle. If any mask bit was set, the iteration changed flag is set.
- CHECK: iter_count += 1, then:
  - If no change in either subiteration: converged=1 → UNLOAD.
  - Else if iter_count == MAX_ITER: converged=0 → UNLOAD.
  - Else → SCAN1.
- UNLOAD:
  - Stream the bitmap in raster order with out_valid held until accepted; out_data must stay stable while out_valid=1 and out_ready=0.
  - After the last beat: done pulses, loaded=0, → IDLE.

## Timing
- Reset values: in_ready=1, busy=0, done=0, out_valid=0, out_data=0, iter_count=0, converged=0. Reset also sets state=IDLE and clears addr, loaded, bitmap and mask.
- Load: one pixel per cycle at full throughput.
- Iteration latency is exactly 2*(IMG_W*IMG_H+1)+1 cycles (two scans, two commits, CHECK).
- First out_valid appears the cycle after CHECK exits. busy falls in the same cycle done pulses.
- Unload: one beat per cycle when out_ready=1. Backpressure stalls the address without loss or duplication.
- rst_n assertion at any point, including mid-scan or mid-unload, aborts immediately. There are no partial outputs after release.
- iter_count and converged hold their values after done until the next accepted start.
- in_valid while in_ready=0 and out_ready while out_valid=0 are ignored.

## Test plan
- All-zero 8x8 image, start → iter_count=1, converged=1, 64 zero beats. done arrives 131 cycles after start accept plus unload.
- Single pixel at (3,3) → B=0, unchanged; iter_count=1, converged=1, only beat 27 = 0xFF.
- Horizontal line row 4, cols 1..5 → A=2 interior and B=1 ends, so the image is unchanged; iter_count=1, converged=1.
- 2x2 block at (1..2,1..2) → all four pixels deleted in SCAN1 of iteration 1; iter_count=2, converged=1, output all zero.
- Same 2x2 block with MAX_ITER=1 → iter_count=1, converged=0, output all zero.
- Random out_ready backpressure on a full 8x8 foreground image, plus rst_n pulsed mid-SCAN2 on a second run → first run's output matches the golden model beat-for-beat; after reset, all reset values hold and in_ready=1.
